// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide for the execute stage.
// One operation per start pulse. Shift-add multiply, restoring divide,
// one iteration per cycle for 32 cycles, then the result is presented with done.
// Optional feature macro: MULDIV_SIGNED_EN adds two's-complement operand
// handling and a FIX state for sign correction. Without it, all operations
// are unsigned and signedOp is ignored.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [5:0]           r_cnt;
    logic [1:0]           r_op;
    logic                 r_dz;      // divisor was zero at latch time
    logic [WIDTH-1:0]     r_a_raw;   // dividend as given, for REM by zero
    logic [WIDTH-1:0]     r_opnd;    // multiplicand (MUL*) or divisor (DIV/REM)
    logic [2*WIDTH-1:0]   r_prod;    // {accumulator, multiplier}
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;     // starts as dividend, fills with quotient bits
    logic [WIDTH-1:0]     r_result;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mac;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic [WIDTH-1:0]     w_final;

`ifdef MULDIV_SIGNED_EN
    logic                 r_sgn;     // signed handling active for this op
    logic                 r_neg_q;   // operand signs differ: negate product/quotient
    logic                 r_neg_r;   // dividend negative: negate remainder
`else
    logic                 w_unused_signed;
    assign w_unused_signed = signedOp;
`endif

    // Operand conditioning: magnitudes when signed handling is in effect
    always_comb begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
`ifdef MULDIV_SIGNED_EN
        w_a_neg = signedOp & srcA[WIDTH-1];
        w_b_neg = signedOp & srcB[WIDTH-1];
`endif
        w_a_mag = w_a_neg ? (~srcA + 1'b1) : srcA;
        w_b_mag = w_b_neg ? (~srcB + 1'b1) : srcB;
    end

    // One multiply step and one restoring-divide step per cycle
    always_comb begin
        w_mac   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_opnd};
    end

    // Output selection; divide-by-zero values bypass the datapath
    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:  w_final = r_prod[WIDTH-1:0];
            OP_MULH: w_final = r_prod[2*WIDTH-1:WIDTH];
            OP_DIV:  w_final = r_dz ? '1 : r_quo;
            OP_REM:  w_final = r_dz ? r_a_raw : r_rem[WIDTH-1:0];
            default: w_final = '0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == LAST_ITER) begin
`ifdef MULDIV_SIGNED_EN
                    w_state_nxt = r_sgn ? S_FIX : S_DONE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch in IDLE, iterate in CALC, correct in FIX, publish in DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_dz     <= 1'b0;
            r_a_raw  <= '0;
            r_opnd   <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
`ifdef MULDIV_SIGNED_EN
            r_sgn    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op    <= op;
                    r_cnt   <= '0;
                    r_a_raw <= srcA;
                    r_dz    <= (srcB == '0);
                    r_opnd  <= op[1] ? w_b_mag : w_a_mag;
                    r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                    r_rem   <= '0;
                    r_quo   <= w_a_mag;
`ifdef MULDIV_SIGNED_EN
                    r_sgn   <= signedOp;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
`endif
                end
                S_CALC: begin
                    r_cnt  <= r_cnt + 6'd1;
                    r_prod <= {w_mac, r_prod[WIDTH-1:1]};
                    if (!w_diff[WIDTH+1]) begin
                        r_rem <= w_diff[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift;
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_FIX: if (!r_dz) begin
                    if (r_neg_q) begin
                        r_prod <= ~r_prod + 1'b1;
                        r_quo  <= ~r_quo + 1'b1;
                    end
                    if (r_neg_r) r_rem <= {1'b0, ~r_rem[WIDTH-1:0] + 1'b1};
                end
`endif
                S_DONE: r_result <= w_final;
                default: ;
            endcase
        end
    end

    // New value is visible in the done cycle, then held by r_result
    assign result = (r_state == S_DONE) ? w_final : r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table-driven vectors plus random
// operations checked against a behavioural model through a scoreboard,
// and hand-written sequences for reset abort and ignored starts.
module tb_mul_div_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clock, reset, start, signedOp, busy, done;
    logic [1:0]  op;
    logic [31:0] srcA, srcB, result;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    logic [31:0] mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .signedOp(signedOp), .srcA(srcA), .srcB(srcB),
        .busy(busy), .done(done), .result(result)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clock) begin
        if (reset && done) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_done: got done with result %h, required no done", result);
            end else begin
                mon_exp = sb_q.pop_front();
                if (result !== mon_exp) begin
                    n_err++;
                    $display("FAIL result: got %h, required %h", result, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic        se;
        logic [63:0] p;
        logic signed [31:0] sa, sb;
        se = s & SEN;
        sa = a;
        sb = b;
        if (!o[1]) begin
            if (se) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            else    p = {32'b0, a} * {32'b0, b};
            return o[0] ? p[63:32] : p[31:0];
        end
        if (b == 32'h0) return o[0] ? a : 32'hFFFF_FFFF;
        if (se && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[0] ? 32'h0 : 32'h8000_0000;
        if (se) return o[0] ? 32'(sa % sb) : 32'(sa / sb);
        return o[0] ? (a % b) : (a / b);
    endfunction

    // Issue one op, check busy profile, done timing/pulse width and result hold.
    // poke: also pulse start in cycle 5 and in the done cycle (both must be ignored).
    task automatic do_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input bit poke);
        int lat;
        bit prof_ok;
        lat = (s && SEN) ? 34 : 33;
        op = o; signedOp = s; srcA = a; srcB = b; start = 1'b1;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        srcA = $urandom; srcB = $urandom; op = 2'($urandom); signedOp = 1'($urandom);
        prof_ok = 1'b1;
        for (int c = 1; c < lat; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) prof_ok = 1'b0;
            if (poke && c == 5) begin
                start = 1'b1; op = 2'b00; srcA = 32'h5; srcB = 32'h3;
            end
            tick();
            start = 1'b0;
        end
        chk("busy_profile", 32'(prof_ok), 32'd1);
        chk("done_at_latency", {30'b0, done, busy}, 32'b10);
        if (poke) begin
            start = 1'b1; op = 2'b00; srcA = 32'h9; srcB = 32'h9;
        end
        tick();
        start = 1'b0;
        chk("after_done_status", {30'b0, done, busy}, 32'b00);
        chk("result_held", result, e);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; signedOp = 1'b0;
        srcA = '0; srcB = '0;

        tbl.push_back('{2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        tbl.push_back('{2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        tbl.push_back('{2'b10, 1'b0, 32'd100,       32'd7,         32'h0000_000E});
        tbl.push_back('{2'b11, 1'b0, 32'd100,       32'd7,         32'h0000_0002});
        tbl.push_back('{2'b10, 1'b0, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF});
        tbl.push_back('{2'b11, 1'b0, 32'h1234_5678, 32'h0,         32'h1234_5678});
        tbl.push_back('{2'b00, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{2'b10, 1'b0, 32'd5,         32'd9,         32'h0});
        tbl.push_back('{2'b11, 1'b0, 32'd5,         32'd9,         32'd5});
        tbl.push_back('{2'b10, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF});
`ifdef MULDIV_SIGNED_EN
        tbl.push_back('{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        tbl.push_back('{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        tbl.push_back('{2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        tbl.push_back('{2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{2'b00, 1'b1, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD});
        tbl.push_back('{2'b01, 1'b1, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF});
        tbl.push_back('{2'b10, 1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF});
        tbl.push_back('{2'b11, 1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9});
`else
        tbl.push_back('{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC});
        tbl.push_back('{2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
`endif

        // Reset state
        repeat (3) tick();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'h0);
        reset = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++)
            do_op(tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);

        // Random operations against the model
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  o;
            logic        s;
            logic [31:0] a, b;
            o = 2'($urandom); s = 1'($urandom); a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op(o, s, a, b, model(o, s, a, b), 1'b0);
        end

        // Ignored starts (busy and done cycle), then accept right after done
        do_op(2'b10, 1'b0, 32'd100, 32'd7, 32'h0000_000E, 1'b1);
        do_op(2'b11, 1'b0, 32'd100, 32'd7, 32'h0000_0002, 1'b0);

        // Reset in cycle 10 of MUL 7x6 aborts with no done
        op = 2'b00; signedOp = 1'b0; srcA = 32'd7; srcB = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        repeat (40) tick();
        chk("abort_result_after", result, 32'h0);
        do_op(2'b00, 1'b0, 32'd7, 32'd6, 32'h0000_002A, 1'b0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
